// File: rtl/mem_req_pkg.sv
// Shared definitions for the execute-stage memory request unit:
// access size encodings, controller state enum and size helpers.
package mem_req_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CANCEL = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [3:0] n;
    n = size_bytes(size) - 4'd1;
    return n[2:0];
  endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Combinational lane generator: misalignment flag, byte strobes and
// lane-replicated store data for one access.
module mem_lane_gen
  import mem_req_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ale_o,
  output logic [NB-1:0]     wstrb_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam logic [2:0] OFF_W_L = 3'(OFF_W);

  logic [3:0]       nbytes_s;
  logic [OFF_W-1:0] off_s;
  logic             oversize_s;

  assign nbytes_s   = size_bytes(size_i);
  assign off_s      = addr_lo_i[OFF_W-1:0];
  assign oversize_s = ({1'b0, size_i} > OFF_W_L);
  assign ale_o      = oversize_s || ((addr_lo_i & align_mask(size_i)) != 3'd0);

  // Lane i is enabled inside [off, off+nbytes); the data pattern repeats every nbytes lanes.
  always_comb begin
    wstrb_o = '0;
    wdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      wstrb_o[i]        = (i >= int'(off_s)) && (i < int'(off_s) + int'(nbytes_s));
      wdata_o[8*i +: 8] = wdata_i[8*(i & (int'(nbytes_s) - 1)) +: 8];
    end
  end

endmodule

// File: rtl/exe_mem_req.sv
// Execute-stage memory request unit: holds one operation, issues a req/addr_ok
// bus request for aligned memory ops, then offers it to the memory stage.
module exe_mem_req
  import mem_req_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEST_W = 5,
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_load,
  output logic              out_signed,
  output logic [1:0]        out_size,
  output logic [DEST_W-1:0] out_dest,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ale,
  output logic              out_discard,
  output logic              req,
  output logic              req_wr,
  output logic [1:0]        req_size,
  output logic [ADDR_W-1:0] req_addr,
  output logic [NB-1:0]     req_wstrb,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              addr_ok
);

  state_e state_q, state_d, route_s;

  logic              accept_s, mem_op_s, ale_s, lane_ale_s;
  logic [NB-1:0]     lane_wstrb_s;
  logic [DATA_W-1:0] lane_wdata_s;

  logic              is_load_q, is_store_q, sign_q, ale_q;
  logic [1:0]        size_q;
  logic [DEST_W-1:0] dest_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  mem_lane_gen #(.DATA_W(DATA_W)) u_lane (
    .size_i    (in_size),
    .addr_lo_i (in_addr[2:0]),
    .wdata_i   (in_wdata),
    .ale_o     (lane_ale_s),
    .wstrb_o   (lane_wstrb_s),
    .wdata_o   (lane_wdata_s)
  );

  assign mem_op_s = in_is_load | in_is_store;
  assign ale_s    = mem_op_s & lane_ale_s;
  assign route_s  = (mem_op_s && !ale_s) ? ST_REQ : ST_DONE;
  assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  // Next-state logic; a request already on the bus is never withdrawn, so a flush in REQ parks in CANCEL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = route_s;
        else          state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (flush)        state_d = addr_ok ? ST_IDLE : ST_CANCEL;
        else if (addr_ok) state_d = ST_DONE;
        else              state_d = ST_REQ;
      end
      ST_CANCEL: begin
        state_d = addr_ok ? ST_IDLE : ST_CANCEL;
      end
      ST_DONE: begin
        if (flush)          state_d = ST_IDLE;
        else if (accept_s)  state_d = route_s;
        else if (out_ready) state_d = ST_IDLE;
        else                state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operation fields are captured on acceptance and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      sign_q     <= 1'b0;
      ale_q      <= 1'b0;
      size_q     <= 2'd0;
      dest_q     <= '0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
    end else if (accept_s) begin
      is_load_q  <= in_is_load;
      is_store_q <= in_is_store;
      sign_q     <= in_signed;
      ale_q      <= ale_s;
      size_q     <= in_size;
      dest_q     <= in_dest;
      addr_q     <= in_addr;
      wstrb_q    <= (in_is_store && !ale_s) ? lane_wstrb_s : '0;
      wdata_q    <= in_is_store ? lane_wdata_s : '0;
    end
  end

  assign req         = (state_q == ST_REQ) || (state_q == ST_CANCEL);
  assign req_wr      = is_store_q;
  assign req_size    = size_q;
  assign req_addr    = addr_q;
  assign req_wstrb   = wstrb_q;
  assign req_wdata   = wdata_q;
  assign out_valid   = (state_q == ST_DONE);
  assign out_is_load = is_load_q;
  assign out_signed  = sign_q;
  assign out_size    = size_q;
  assign out_dest    = dest_q;
  assign out_addr    = addr_q;
  assign out_ale     = ale_q;
  // A cancelled load's address is accepted now; its response must be dropped downstream.
  assign out_discard = is_load_q && addr_ok &&
                       (((state_q == ST_REQ) && flush) || (state_q == ST_CANCEL));

endmodule

// File: doc/exe_mem_req.md
# exe_mem_req

Parametrised execute-stage memory request unit. It sits between the ALU half of the execute stage and the memory stage, and replaces the single-cycle, always-enabled data SRAM port with a req/addr_ok handshake bus. Data width is configurable (32/64) and access size runs up to a doubleword. It also performs misalignment (ALE) detection and flush cancellation. It holds one operation at a time: it issues the memory request, waits for address acceptance, then hands the operation to the memory stage with valid/ready.

## Interface
Parameters:
- DATA_W, 32: bus data width; 32 or 64 only. NB = DATA_W/8; OFF_W = log2(NB).
- ADDR_W, 32: address width.
- DEST_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush (exception/branch); has priority over everything.
- in_valid  in  1  operation offered by the ALU half.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_is_load, in_is_store  in  1 each  memory op class; both 0 = non-memory op.
- in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- in_signed  in  1  load sign-extension flag; passed through.
- in_addr  in  ADDR_W  effective address (ALU result).
- in_wdata  in  DATA_W  store data; low 2^in_size bytes significant.
- in_dest  in  DEST_W  destination register index; passed through.
- out_valid  out  1  operation ready for the memory stage.
- out_ready  in  1  memory stage accepts.
- out_is_load, out_signed, out_size, out_dest, out_addr  out  as inputs  registered copies.
- out_ale  out  1  misaligned access; no bus request was issued.
- out_discard  out  1  one-cycle pulse; a cancelled load's response must be dropped by the memory stage.
- req  out  1  bus request.
- req_wr  out  1  1 = store.
- req_size  out  2  = registered in_size.
- req_addr  out  ADDR_W  unaligned byte address.
- req_wstrb  out  NB  byte enables; zero for loads.
- req_wdata  out  DATA_W  lane-replicated store data.
- addr_ok  in  1  bus accepted the request this cycle.

## Operation
- States: IDLE, REQ, CANCEL, DONE. Reset → IDLE; all outputs 0.
- in_ready = !flush && (IDLE || (DONE && out_ready)). out_valid = DONE.
- Acceptance routes the operation as follows:
  - If it is a memory op and not ALE, state → REQ.
  - Otherwise (non-memory op, or any ALE) state → DONE.
  - All fields are registered on acceptance.
- ALE rule: addr[size-1:0] != 0, or size > OFF_W (dword on a 32-bit bus). ALE stores produce no strobe and no request.
- REQ:
  - req = 1; the request fields are held stable until addr_ok.
  - addr_ok moves the state to DONE.
- DONE: on out_ready, either accept a new operation (same cycle) or go to IDLE.
- Lane generation:
  - off = addr[OFF_W-1:0].
  - req_wstrb = ((1<<2^size)-1) << off, for stores only.
  - req_wdata = low 2^size bytes of in_wdata replicated across NB lanes.
- Flush:
  - IDLE or DONE → IDLE.
  - REQ with addr_ok the same cycle → IDLE, and out_discard = out_is_load.
  - REQ without addr_ok → CANCEL.
  - CANCEL: req stays 1 (a request is never withdrawn) with out_valid 0. On addr_ok the state goes to IDLE with out_discard = out_is_load.
  - A flush arriving while in CANCEL changes nothing.
- out_discard is combinational from state and addr_ok.

## Timing
- Memory op: accept at cycle 0, req high from cycle 1. With addr_ok in cycle k, out_valid is high from cycle k+1.
- Best-case memory op throughput is 1 per 2 cycles. Non-memory and ALE ops reach out_valid at cycle 1, with back-to-back throughput of 1/cycle.
- Output fields are stable while out_valid && !out_ready.
- reset mid-REQ or mid-CANCEL drops req the next cycle; the bus is reset together with the unit.

## Structure
- Shared package mem_req_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum;
  - the helper function size_bytes.
- Sub-module mem_lane_gen: combinational; produces the ALE flag, req_wstrb and req_wdata from size/addr/wdata.
- The top level holds the FSM and registers.

## Test plan
- DATA_W=32: store word 0x11223344 to addr 0x1006 (half, size 1). Required: req_wstrb 0b1100, req_wdata 0x33443344, out_ale 0.
- DATA_W=64: load dword at 0x2004. Required: out_ale 1, req never asserted, out_valid at cycle 1. The same load with DATA_W=32 and addr 0x2000 is also ALE (size > OFF_W).
- Hold addr_ok low for 3 cycles after req, then pulse it. Required: req_addr/req_wstrb constant throughout; out_valid exactly one cycle after addr_ok.
- Load in REQ, flush at cycle 2, addr_ok at cycle 4. Required: req held through cycle 4, out_discard=1 at cycle 4, out_valid never 1, IDLE at cycle 5.
- Back-to-back non-memory ops with out_ready=1. Required: one output per cycle. Deassert out_ready for 2 cycles: in_ready=0 and outputs frozen.
- flush and in_valid in the same cycle from IDLE. Required: the operation is not accepted, and state stays IDLE.
